// File: rtl/bcd_bin_seq.sv
// Packed-BCD to binary converter, one digit per clock MSD first (acc = acc*10 + digit),
// with valid/ready handshakes, sticky illegal-digit and overflow flags.
module bcd_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // One-hot so the handshake outputs come straight off state flops.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CONV = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t                state, state_nxt;
  logic [4*DIGITS-1:0]   word;
  logic [CNT_W-1:0]      cnt;
  logic [BIN_W-1:0]      acc;
  logic [3:0]            dig;
  logic [BIN_W+3:0]      acc_wide;
  logic                  last;
  logic                  dig_bad;

  // The latched word shifts left each step, so the current digit is always the top nibble.
  assign dig      = word[4*DIGITS-1 -: 4];
  assign dig_bad  = (dig > 4'd9);
  assign acc_wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{BIN_W{1'b0}}, dig};
  assign last     = (cnt == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: acc is kept reduced modulo 2^BIN_W; ovf catches the first step whose
  // unreduced value spills into the top nibble, which is exact while acc is still unreduced.
  always_ff @(posedge clk) begin
    if (rst) begin
      word    <= '0;
      cnt     <= '0;
      acc     <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      bin_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word <= bcd_in;
            cnt  <= '0;
            acc  <= '0;
            err  <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        CONV: begin
          word <= word << 4;
          cnt  <= cnt + 1'b1;
          acc  <= acc_wide[BIN_W-1:0];
          if (dig_bad)                      err <= 1'b1;
          if (|acc_wide[BIN_W+3:BIN_W])     ovf <= 1'b1;
          if (last) bin_out <= (err || dig_bad) ? '0 : acc_wide[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
